// File: rtl/unified_mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port RAM (1-cycle read latency).
// Optional I-port starvation guard: define UNIFIED_MEM_ARBITER_STARVE_GUARD_EN.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic              d_write,
    input  logic [1:0]        d_width,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_cke,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_width,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, I_RESP, D_RESP} state_t;

    localparam logic [1:0] WIDTH_WORD = 2'b10;

    state_t state;
    state_t next_state;
    logic   resp_write;
    logic   fetch_ok;
    logic   i_promote;

    assign fetch_ok = i_req & ~i_flush;

`ifdef UNIFIED_MEM_ARBITER_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign i_promote = (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset)
            starve_cnt <= '0;
        else if (i_req && d_req && i_flush)
            starve_cnt <= starve_cnt;  // three-way collision leaves the count untouched
        else if (i_gnt || !i_req || i_flush)
            starve_cnt <= '0;
        else if (starve_cnt != CNT_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    logic unused_starve_cfg;

    assign unused_starve_cfg = (STARVE_LIMIT > 0);
    assign i_promote         = 1'b0;
`endif

    always_comb begin
        // NOTE: defaults first, so no branch of this block can infer a latch.
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!p_reset) begin
            if (fetch_ok && i_promote)
                i_gnt = 1'b1;
            else if (d_req)
                d_gnt = 1'b1;
            else if (fetch_ok)
                i_gnt = 1'b1;
        end
    end

    assign mem_cke = i_gnt | d_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_width = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_we    = d_write;
            mem_width = d_width;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
            mem_width = WIDTH_WORD;
        end
    end

    // Next state depends only on this cycle's grant, so responses pipeline back-to-back.
    always_comb begin
        next_state = IDLE;
        if (i_gnt)
            next_state = I_RESP;
        else if (d_gnt)
            next_state = D_RESP;
    end

    always_ff @(posedge m_clock or posedge p_reset) begin
        // NOTE: non-blocking assignments, so every flop samples values from before the edge.
        if (p_reset) begin
            state      <= IDLE;
            resp_write <= 1'b0;
        end else begin
            state      <= next_state;
            resp_write <= d_gnt & d_write;
        end
    end

    assign i_rvalid = (state == I_RESP) & ~i_flush;
    assign d_rvalid = (state == D_RESP);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = (d_rvalid && !resp_write) ? mem_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed table, multi-cycle corner cases, random vs. reference model.
// Starvation expectations follow UNIFIED_MEM_ARBITER_STARVE_GUARD_EN exactly as the design build does.
module tb_unified_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LIMIT  = 4;

    logic              m_clock = 1'b0;
    logic              p_reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_write;
    logic [1:0]        d_width;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_cke;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [1:0]        mem_width;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .m_clock(m_clock), .p_reset(p_reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write), .d_width(d_width),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_cke(mem_cke), .mem_addr(mem_addr), .mem_we(mem_we), .mem_width(mem_width),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 m_clock = ~m_clock;

    // Behavioural single-port RAM: 256 words, read data one cycle after the command.
    logic [31:0] ram [0:255];
    logic [31:0] rd_q;
    logic [7:0]  widx;

    assign widx      = mem_addr[9:2];
    assign mem_rdata = rd_q;

    initial begin
        rd_q <= '0;
        for (int i = 0; i < 256; i++) ram[i] <= 32'h0101_0101 * 32'(i);
    end

    always @(posedge m_clock) begin
        if (mem_cke) begin
            if (mem_we) begin
                case (mem_width)
                    2'b00:   ram[widx][{mem_addr[1:0], 3'b000} +: 8]  <= mem_wdata[7:0];
                    2'b01:   ram[widx][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                    default: ram[widx] <= mem_wdata;
                endcase
                rd_q <= 32'hA5A5_5A5A;
            end else begin
                rd_q <= ram[widx];
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_req = 1'b0; d_addr = '0; d_wdata = '0; d_write = 1'b0; d_width = 2'b00;
    endtask

    task automatic next_cycle();
        @(posedge m_clock);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 64'({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_cke, mem_we}), 64'(0));
        check({name, "_rdata"}, 64'({i_rdata, d_rdata}), 64'(0));
    endtask

    // Requests are held high during reset so the zero checks mean something.
    task automatic do_reset();
        drive_idle();
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_write = 1'b1;
        p_reset = 1'b1;
        repeat (2) @(posedge m_clock);
        @(negedge m_clock);
        check_all_zero("reset");
        drive_idle();
        p_reset = 1'b0;
        next_cycle();
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        fl;
        logic        dr;
        logic [31:0] da;
        logic [31:0] dw;
        logic        dwr;
        logic [1:0]  dwd;
        logic        eig;
        logic        edg;
        logic        eiv;
        logic        edv;
        logic [31:0] eird;
        logic [31:0] edrd;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic fl,
                                input logic dr, input logic [31:0] da, input logic [31:0] dw,
                                input logic dwr, input logic [1:0] dwd,
                                input logic eig, input logic edg, input logic eiv, input logic edv,
                                input logic [31:0] eird, input logic [31:0] edrd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.fl = fl; v.dr = dr; v.da = da; v.dw = dw; v.dwr = dwr; v.dwd = dwd;
        v.eig = eig; v.edg = edg; v.eiv = eiv; v.edv = edv; v.eird = eird; v.edrd = edrd;
        return v;
    endfunction

    // Reference model state: the outstanding response and the I-port blocked streak.
    typedef enum {P_NONE, P_IFETCH, P_DREAD, P_DWRITE} pend_e;

    pend_e       pend;
    logic [31:0] pend_data;
    int          blocked;

    vec_t tbl [11];

    initial begin
        logic        exp_i;
        logic        promote;
        logic        e_ig;
        logic        e_dg;
        logic        e_iv;
        logic        e_dv;
        logic        e_we;
        logic [31:0] e_addr;
        logic [1:0]  e_width;
        logic [31:0] e_wdata;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
        logic        hold_i;
        logic        hold_d;
        int          a;

        tbl[0]  = mk(1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        tbl[1]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0404_0404, 32'h0);
        tbl[2]  = mk(1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        tbl[3]  = mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0);
        tbl[4]  = mk(1'b0, 32'h0,  1'b0, 1'b1, 32'h80, 32'h0,         1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1010_1010, 32'h0);
        tbl[5]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'hDEAD_BEEF);
        tbl[6]  = mk(1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        tbl[7]  = mk(1'b1, 32'h24, 1'b1, 1'b0, 32'h0,  32'h0,         1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        tbl[8]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        tbl[9]  = mk(1'b1, 32'h30, 1'b1, 1'b1, 32'h0C, 32'h0,         1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        tbl[10] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0303_0303);

        drive_idle();
        p_reset = 1'b1;
        #1;
        check_all_zero("reset_async");
        do_reset();

        // Directed table: fetch, D-over-I priority with write/readback, flush, three-way collision.
        for (int r = 0; r < 11; r++) begin
            i_req = tbl[r].ir; i_addr = tbl[r].ia; i_flush = tbl[r].fl;
            d_req = tbl[r].dr; d_addr = tbl[r].da; d_wdata = tbl[r].dw;
            d_write = tbl[r].dwr; d_width = tbl[r].dwd;
            @(negedge m_clock);
            check($sformatf("tbl%0d_gnt", r), 64'({i_gnt, d_gnt, mem_cke}),
                  64'({tbl[r].eig, tbl[r].edg, tbl[r].eig | tbl[r].edg}));
            check($sformatf("tbl%0d_rvalid", r), 64'({i_rvalid, d_rvalid}), 64'({tbl[r].eiv, tbl[r].edv}));
            check($sformatf("tbl%0d_rdata", r), 64'({i_rdata, d_rdata}), 64'({tbl[r].eird, tbl[r].edrd}));
            next_cycle();
        end

        // Six cycles of contention: the guard promotes the I-port once the count saturates.
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            drive_idle();
            i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h0; d_width = 2'b10;
            @(negedge m_clock);
`ifdef UNIFIED_MEM_ARBITER_STARVE_GUARD_EN
            exp_i = (c == 5);
`else
            exp_i = 1'b0;
`endif
            check($sformatf("starve_c%0d", c), 64'({i_gnt, d_gnt}), 64'({exp_i, ~exp_i}));
            next_cycle();
        end

        // Reset pulsed while a load response is in flight.
        do_reset();
        drive_idle();
        d_req = 1'b1; d_addr = 32'h0C; d_width = 2'b10;
        @(negedge m_clock);
        check("rst_mid_dgnt", 64'(d_gnt), 64'(1));
        next_cycle();
        i_req = 1'b1; d_req = 1'b1; d_addr = 32'h0;
        p_reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge m_clock);
        drive_idle();
        p_reset = 1'b0;
        next_cycle();
        @(negedge m_clock);
        check_all_zero("rst_after");
        next_cycle();

        // Randomised traffic against the reference model.
        do_reset();
        pend = P_NONE; pend_data = '0; blocked = 0;
        hold_i = 1'b0; hold_d = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!hold_i) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = 32'($urandom_range(0, 255)) << 2;
            end
            i_flush = ($urandom_range(0, 4) == 0);
            if (!hold_d) begin
                d_req   = ($urandom_range(0, 1) != 0);
                d_write = ($urandom_range(0, 2) == 0);
                d_width = 2'($urandom_range(0, 2));
                d_wdata = $urandom;
                a = $urandom_range(0, 1023);
                if (d_width == 2'b01) a = a & ~1;
                if (d_width == 2'b10) a = a & ~3;
                d_addr = 32'(a);
            end

`ifdef UNIFIED_MEM_ARBITER_STARVE_GUARD_EN
            promote = (blocked == LIMIT);
`else
            promote = 1'b0;
`endif
            e_ig = i_req && !i_flush && (promote || !d_req);
            e_dg = d_req && !e_ig;
            e_addr = '0; e_we = 1'b0; e_width = 2'b00; e_wdata = '0;
            if (e_dg) begin
                e_addr = d_addr; e_we = d_write; e_width = d_width; e_wdata = d_wdata;
            end else if (e_ig) begin
                e_addr = i_addr; e_width = 2'b10;
            end
            e_iv  = (pend == P_IFETCH) && !i_flush;
            e_dv  = (pend == P_DREAD) || (pend == P_DWRITE);
            e_ird = e_iv ? pend_data : 32'h0;
            e_drd = (pend == P_DREAD) ? pend_data : 32'h0;

            @(negedge m_clock);
            check($sformatf("rnd%0d_ctl", n), 64'({i_gnt, d_gnt, mem_cke, mem_we}),
                  64'({e_ig, e_dg, e_ig | e_dg, e_we}));
            check($sformatf("rnd%0d_addr", n), 64'(mem_addr), 64'(e_addr));
            check($sformatf("rnd%0d_wr", n), 64'({mem_width, mem_wdata}), 64'({e_width, e_wdata}));
            check($sformatf("rnd%0d_rvalid", n), 64'({i_rvalid, d_rvalid}), 64'({e_iv, e_dv}));
            check($sformatf("rnd%0d_rdata", n), 64'({i_rdata, d_rdata}), 64'({e_ird, e_drd}));

            if (e_ig) begin
                pend = P_IFETCH; pend_data = ram[i_addr[9:2]];
            end else if (e_dg) begin
                pend = d_write ? P_DWRITE : P_DREAD; pend_data = ram[d_addr[9:2]];
            end else begin
                pend = P_NONE; pend_data = '0;
            end
            if (!(i_req && d_req && i_flush)) begin
                if (e_ig || !i_req || i_flush) blocked = 0;
                else if (blocked < LIMIT) blocked = blocked + 1;
            end
            hold_i = i_req && !e_ig;
            hold_d = d_req && !e_dg;
            next_cycle();
        end

        drive_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
